fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the fetch-to-decode bus. It holds the PC and issues one instruction-memory read at a time. Each returned instruction word is packed with its PC into a fetch-to-decode packet and sent to decode only when the bus is not busy. The stage also accepts PC redirects from execute and squashes any wrong-path fetch.

Parameters:
ADDR_W, 32, PC / memory address width
INSN_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment after each packet sent

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_req_valid  out  1  instruction read request
mem_req_addr  out  ADDR_W  request address (= pc)
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  read data valid (exactly one per accepted request, ≥1 cycle after accept)
mem_resp_data  in  INSN_W  instruction word
redirect_valid  in  1  one-cycle PC redirect from execute
redirect_pc  in  ADDR_W  redirect target
dec_busy  in  1  bus holds an unconsumed packet (bus is_busy flag)
dec_send  out  1  one-cycle packet send pulse (writes bus data, sets is_busy)
dec_pkt_pc  out  ADDR_W  packet PC
dec_pkt_insn  out  INSN_W  packet instruction
fetch_count  out  32  number of packets sent, wraps mod 2^32

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, hold regs=0, fetch_count=0.
- While reset is asserted, mem_req_valid=0 and dec_send=0. mem_req_valid=1 in the first cycle after release.
- Output rules:
  - mem_req_valid=1 only in FETCH; mem_req_addr=pc at all times.
  - dec_pkt_pc / dec_pkt_insn are 0 whenever dec_send=0.
  - dec_send is combinational and is never 1 while dec_busy=1 or while redirect_valid=1.
- States:
  - FETCH: on mem_req_ready, go to WAIT.
  - WAIT, on mem_resp_valid:
    - dec_busy=0: dec_send=1 with {pc, mem_resp_data}; pc+=PC_STEP; go to FETCH.
    - dec_busy=1: latch {pc, data} into hold regs; go to HOLD.
  - HOLD: when dec_busy=0, dec_send=1 with hold regs; pc+=PC_STEP; go to FETCH.
  - DRAIN: discard the outstanding response. On mem_resp_valid, go to FETCH; no send.
- Redirect (priority over everything, in every state): pc<=redirect_pc, no dec_send that cycle.
  - FETCH with mem_req_ready=1 same cycle: the request was accepted, go to DRAIN. With mem_req_ready=0: stay in FETCH.
  - WAIT with mem_resp_valid=1 same cycle: drop the response, go to FETCH. Without response: go to DRAIN.
  - HOLD: drop the held instruction, go to FETCH.
  - DRAIN: stay in DRAIN (pc updated).
- PC arithmetic is mod 2^ADDR_W; wrap from all-ones region to low addresses is legal.
- fetch_count increments exactly on each dec_send.
- At most one outstanding memory request at any time.
- Throughput with 1-cycle memory and idle decode: one packet every 2 cycles.
- mem_resp_valid outside WAIT/DRAIN is a protocol error: ignored; a simulation assertion flags it.

Test Plan:
- Reset release, 1-cycle memory, dec_busy=0 → mem_req_addr 0, 4, 8. dec_send every 2nd cycle with pkts {0, I0}, {4, I1}, {8, I2}. fetch_count=3.
- Response arrives while dec_busy=1 for 3 cycles → HOLD, no dec_send. dec_send with the held {pc, insn} in the first cycle dec_busy=0. Next request addr = pc+4.
- Redirect to 0x100 while in WAIT, response 2 cycles later → response discarded, no dec_send. Next mem_req_addr=0x100. The packet for 0x100 is sent with the correct insn.
- Redirect to 0x200 in the same cycle as the response in WAIT → no send. mem_req_valid with addr 0x200 next cycle; nothing is drained.
- Redirect in HOLD, then a second redirect during DRAIN → held packet never sent. Fetch resumes at the second target only.
- Async reset asserted mid-WAIT → outputs 0 immediately. After release: addr=RESET_PC, fetch_count=0. A stale response during reset is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage that feeds the fetch-to-decode bus.
//
// The stage holds the PC and keeps at most one instruction-memory read in
// flight. Each returned word is paired with its PC and sent to decode as a
// one-cycle pulse, but only while the bus is free. If the bus is busy, the
// word is parked in hold registers until the bus frees up. A redirect from
// execute replaces the PC and squashes any wrong-path fetch. That squashed
// fetch can be a response arriving now, a parked word, or a request still
// in flight.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   mem_req_*         read request (valid/ready handshake, address = pc)
//   mem_resp_*        read response (one per accepted request)
//   redirect_*        one-cycle PC redirect from execute
//   dec_busy          the bus still holds an unconsumed packet
//   dec_send          one-cycle send pulse carrying dec_pkt_pc/dec_pkt_insn
//   fetch_count       packets sent so far (wraps)
module fetch_stage #(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         INSN_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [INSN_W-1:0] mem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_busy,
    output logic              dec_send,
    output logic [ADDR_W-1:0] dec_pkt_pc,
    output logic [INSN_W-1:0] dec_pkt_insn,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   hold_pc_q;
    logic [INSN_W-1:0]   hold_insn_q;
    logic [31:0]         fetch_count_q;
    logic                send_direct;
    logic                send_hold;

    // A redirect this cycle suppresses any send, because the packet would be
    // from the wrong path.
    always_comb begin
        send_direct  = (state_q == S_WAIT) && mem_resp_valid && !dec_busy && !redirect_valid;
        send_hold    = (state_q == S_HOLD) && !dec_busy && !redirect_valid;
        dec_send     = send_direct || send_hold;
        dec_pkt_pc   = '0;
        dec_pkt_insn = '0;
        if (send_direct) begin
            dec_pkt_pc   = pc_q;
            dec_pkt_insn = mem_resp_data;
        end else if (send_hold) begin
            dec_pkt_pc   = hold_pc_q;
            dec_pkt_insn = hold_insn_q;
        end
        pc_d = pc_q + PC_STEP;
    end

    // During reset the state already reads FETCH. The request is gated here
    // so that nothing is issued before reset is released.
    assign mem_req_valid = (state_q == S_FETCH) && !reset;
    assign mem_req_addr  = pc_q;
    assign fetch_count   = fetch_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            hold_pc_q     <= '0;
            hold_insn_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            if (dec_send) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (redirect_valid) begin
                pc_q <= redirect_pc;
                unique case (state_q)
                    // A request accepted this same cycle is still in flight,
                    // so its response must be drained.
                    S_FETCH: if (mem_req_ready) state_q <= S_DRAIN;
                    S_WAIT:  state_q <= mem_resp_valid ? S_FETCH : S_DRAIN;
                    S_HOLD:  state_q <= S_FETCH;
                    S_DRAIN: state_q <= S_DRAIN;
                    default: state_q <= S_FETCH;
                endcase
            end else begin
                unique case (state_q)
                    S_FETCH: begin
                        if (mem_req_ready) state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (mem_resp_valid) begin
                            if (!dec_busy) begin
                                pc_q    <= pc_d;
                                state_q <= S_FETCH;
                            end else begin
                                hold_pc_q   <= pc_q;
                                hold_insn_q <= mem_resp_data;
                                state_q     <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!dec_busy) begin
                            pc_q    <= pc_d;
                            state_q <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (mem_resp_valid) state_q <= S_FETCH;
                    end
                    default: state_q <= S_FETCH;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A response with no request outstanding is ignored by the logic above.
    // It still indicates a broken memory model.
    resp_protocol_chk: assert property (
        @(posedge clk) disable iff (reset)
        mem_resp_valid |-> (state_q == S_WAIT || state_q == S_DRAIN)
    ) else $error("mem_resp_valid with no outstanding request");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Inputs change on the falling edge.
// Outputs are sampled 1ns later, which is well before the next rising edge.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_busy;
    logic        dec_send;
    logic [31:0] dec_pkt_pc;
    logic [31:0] dec_pkt_insn;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // Observed output bundle: {req_valid, req_addr, send, pkt_pc, pkt_insn}
    logic [97:0] obs;
    logic [97:0] exp;
    assign obs = {mem_req_valid, mem_req_addr, dec_send, dec_pkt_pc, dec_pkt_insn};

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_busy       (dec_busy),
        .dec_send       (dec_send),
        .dec_pkt_pc     (dec_pkt_pc),
        .dec_pkt_insn   (dec_pkt_insn),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge, then settle.
    task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                         input logic busy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        mem_req_ready  = rdy;
        mem_resp_valid = rsp;
        mem_resp_data  = data;
        dec_busy       = busy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fetch_count); end
        @(negedge clk); reset = 1'b0; #1;
        exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp); end
    endtask

    task automatic test_stream();
        logic [31:0] insn [3];
        logic [31:0] a;
        insn[0] = 32'h1000_0013; insn[1] = 32'h2000_0093; insn[2] = 32'h3000_0113;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            exp = {1'b1, a, 1'b0, 32'h0, 32'h0};
            total++; if (obs !== exp) begin bad++; $display("FAIL stream_req%0d got=%h want=%h", i, obs, exp); end
            drive(1'b0, 1'b1, insn[i], 1'b0, 1'b0, 32'h0);
            exp = {1'b0, a, 1'b1, a, insn[i]};
            total++; if (obs !== exp) begin bad++; $display("FAIL stream_send%0d got=%h want=%h", i, obs, exp); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'hC, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL stream_next got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stream_count got=%0d want=3", fetch_count); end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0);
        exp = {1'b0, 32'hC, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL hold_busy_resp got=%h want=%h", obs, exp); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            total++; if (obs !== exp) begin bad++; $display("FAIL hold_wait%0d got=%h want=%h", i, obs, exp); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'hC, 1'b1, 32'hC, 32'hAAAA_5555};
        total++; if (obs !== exp) begin bad++; $display("FAIL hold_send got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'h10, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL hold_next_req got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL hold_count got=%0d want=4", fetch_count); end
    endtask

    task automatic test_redirect_wait();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        exp = {1'b0, 32'h10, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rw_redirect got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h100, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rw_drain got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        total++; if (obs !== exp) begin bad++; $display("FAIL rw_discard got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rw_req got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h100, 1'b1, 32'h100, 32'h1111_1111};
        total++; if (obs !== exp) begin bad++; $display("FAIL rw_send got=%h want=%h", obs, exp); end
    endtask

    task automatic test_redirect_same();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL rs_count_before got=%0d want=5", fetch_count); end
        drive(1'b0, 1'b1, 32'hBEEF_BEEF, 1'b0, 1'b1, 32'h200);
        exp = {1'b0, 32'h104, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rs_no_send got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'h200, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rs_req got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h200, 1'b1, 32'h200, 32'h2222_2222};
        total++; if (obs !== exp) begin bad++; $display("FAIL rs_send got=%h want=%h", obs, exp); end
    endtask

    task automatic test_redirect_hold_drain();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
        exp = {1'b0, 32'h204, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_hold_redirect got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
        exp = {1'b1, 32'h300, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_fetch_redirect got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
        exp = {1'b0, 32'h400, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_drain_redirect got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 32'hCAFE_CAFE, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h500, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_drain_resp got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'h500, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_resume got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd6) begin bad++; $display("FAIL rhd_count got=%0d want=6", fetch_count); end
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h500, 1'b1, 32'h500, 32'h5555_5555};
        total++; if (obs !== exp) begin bad++; $display("FAIL rhd_send got=%h want=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exp = {1'b1, 32'h504, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_redirect got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_req got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h9999_9999};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_send got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap_next got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL wrap_count got=%0d want=8", fetch_count); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h600, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL ar_in_wait got=%h want=%h", obs, exp); end
        #2 reset = 1'b1;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL ar_immediate got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", fetch_count); end
        drive(1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
        total++; if (obs !== exp) begin bad++; $display("FAIL ar_stale_resp got=%h want=%h", obs, exp); end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        reset = 1'b0;
        #1;
        exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        total++; if (obs !== exp) begin bad++; $display("FAIL ar_release got=%h want=%h", obs, exp); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL ar_release_count got=%0d want=0", fetch_count); end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        exp = {1'b0, 32'h0, 1'b1, 32'h0, 32'h1234_5678};
        total++; if (obs !== exp) begin bad++; $display("FAIL ar_first_send got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL ar_final_count got=%0d want=1", fetch_count); end
    endtask

    initial begin
        reset          = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_busy       = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_redirect_wait();
        test_redirect_same();
        test_redirect_hold_drain();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
